// File: rtl/gp_dma_pkg.sv
// Shared constants and state encoding for the gp_dma channel requesters.
package gp_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_XFER = 3'd2,
        ST_REL  = 3'd3,
        ST_DONE = 3'd4
    } chan_state_e;

    localparam int BURST_MAX_DEF = 8;
    localparam int ADDR_INC_DEF  = 4;
    localparam int NUM_CHAN      = 4;

endpackage

// File: rtl/gp_dma_beat_cnt.sv
// Remaining/tenure beat down-counters and the beat address incrementer.
module gp_dma_beat_cnt #(
    parameter int AW        = 32,
    parameter int CNT_W     = 16,
    parameter int BURST_MAX = 8,
    parameter int ADDR_INC  = 4,
    parameter int TB_W      = $clog2(BURST_MAX + 1)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             load_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic [3:0]       burst_i,
    input  logic             tload_i,
    input  logic             step_i,
    output logic [AW-1:0]    addr_o,
    output logic             rem_zero_o,
    output logic             rem_last_o,
    output logic             tb_last_o
);

    localparam logic [3:0] BMAX4 = 4'(BURST_MAX);

    logic [AW-1:0]    addr_q,  addr_d;
    logic [CNT_W-1:0] rem_q,   rem_d;
    logic [TB_W-1:0]  tb_q,    tb_d;
    logic [TB_W-1:0]  burst_q, burst_d;

    always_comb begin
        addr_d  = addr_q;
        rem_d   = rem_q;
        tb_d    = tb_q;
        burst_d = burst_q;
        if (load_i) begin
            addr_d  = addr_i;
            rem_d   = len_i;
            // zero and oversize requests both fall back to the maximum burst
            burst_d = (burst_i == 4'd0 || burst_i > BMAX4) ? TB_W'(BURST_MAX) : TB_W'(burst_i);
        end else if (tload_i) begin
            tb_d = (rem_q < CNT_W'(burst_q)) ? TB_W'(rem_q) : burst_q;
        end else if (step_i) begin
            addr_d = addr_q + AW'(ADDR_INC);
            rem_d  = rem_q - 1'b1;
            tb_d   = tb_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            addr_q  <= '0;
            rem_q   <= '0;
            tb_q    <= '0;
            burst_q <= '0;
        end else begin
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            tb_q    <= tb_d;
            burst_q <= burst_d;
        end
    end

    assign addr_o     = addr_q;
    assign rem_zero_o = (rem_q == '0);
    assign rem_last_o = (rem_q == CNT_W'(1));
    assign tb_last_o  = (tb_q == TB_W'(1));

endmodule

// File: rtl/gp_dma_chan_req.sv
// Per-channel requester: raises dma_pending, holds the bus on grant, issues
// a tenure of address beats, then releases for re-arbitration.
module gp_dma_chan_req
    import gp_dma_pkg::*;
#(
    parameter int AW        = 32,
    parameter int CNT_W     = 16,
    parameter int BURST_MAX = BURST_MAX_DEF,
    parameter int ADDR_INC  = ADDR_INC_DEF
) (
    input  logic             cbus_clk_i,
    input  logic             cbus_rst_i,
    input  logic             cfg_start_i,
    input  logic             cfg_abort_i,
    input  logic [AW-1:0]    cfg_addr_i,
    input  logic [CNT_W-1:0] cfg_len_i,
    input  logic [3:0]       cfg_burst_i,
    input  logic [2:0]       cfg_pri_i,
    input  logic             owner_sel_i,
    input  logic             cycle_start_i,
    output logic             dma_pending_o,
    output logic [2:0]       priority_o,
    output logic             active_o,
    output logic             bus_valid_o,
    output logic [AW-1:0]    bus_addr_o,
    input  logic             bus_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o
);

    chan_state_e state_q, state_d;
    logic        aborted_q, aborted_d;
    logic        abort_pend_q, abort_pend_d;
    logic [2:0]  pri_q, pri_d;
    logic        load, tload, accept;
    logic        rem_zero, rem_last, tb_last;

    assign accept = (state_q == ST_XFER) && bus_ready_i;

    gp_dma_beat_cnt #(
        .AW(AW), .CNT_W(CNT_W), .BURST_MAX(BURST_MAX), .ADDR_INC(ADDR_INC)
    ) u_beat_cnt (
        .clk_i      (cbus_clk_i),
        .srst_i     (cbus_rst_i),
        .load_i     (load),
        .addr_i     (cfg_addr_i),
        .len_i      (cfg_len_i),
        .burst_i    (cfg_burst_i),
        .tload_i    (tload),
        .step_i     (accept),
        .addr_o     (bus_addr_o),
        .rem_zero_o (rem_zero),
        .rem_last_o (rem_last),
        .tb_last_o  (tb_last)
    );

    always_comb begin
        state_d      = state_q;
        aborted_d    = aborted_q;
        abort_pend_d = abort_pend_q;
        pri_d        = pri_q;
        load         = 1'b0;
        tload        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start_i) begin
                    load         = 1'b1;
                    pri_d        = cfg_pri_i;
                    aborted_d    = 1'b0;
                    abort_pend_d = 1'b0;
                    state_d      = (cfg_len_i == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (cfg_abort_i) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (owner_sel_i && cycle_start_i) begin
                    tload   = 1'b1;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (accept) begin
                    abort_pend_d = 1'b0;
                    if (rem_last) begin
                        // the final beat wins over a coincident abort
                        state_d = ST_REL;
                    end else if (tb_last || cfg_abort_i || abort_pend_q) begin
                        aborted_d = cfg_abort_i || abort_pend_q;
                        state_d   = ST_REL;
                    end
                end else if (cfg_abort_i) begin
                    abort_pend_d = 1'b1;
                end
            end
            ST_REL: begin
                if (cfg_abort_i && !rem_zero) begin
                    aborted_d = 1'b1;
                end
                state_d = (rem_zero || aborted_q || cfg_abort_i) ? ST_DONE : ST_REQ;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge cbus_clk_i) begin
        if (cbus_rst_i) begin
            state_q      <= ST_IDLE;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            pri_q        <= 3'd0;
        end else begin
            state_q      <= state_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
            pri_q        <= pri_d;
        end
    end

    assign dma_pending_o = (state_q == ST_REQ) || (state_q == ST_XFER);
    assign active_o      = (state_q == ST_XFER);
    assign bus_valid_o   = (state_q == ST_XFER);
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE);
    assign aborted_o     = aborted_q;
    assign priority_o    = pri_q;

endmodule

// File: tb/tb_gp_dma_chan_req.sv
// Directed bench for gp_dma_chan_req with a small auto-granting arbiter stub.
module tb_gp_dma_chan_req;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cfg_start, cfg_abort;
    logic [31:0] cfg_addr;
    logic [15:0] cfg_len;
    logic [3:0]  cfg_burst;
    logic [2:0]  cfg_pri;
    logic        owner_sel, cycle_start, bus_ready;
    logic        dma_pending, active, bus_valid, busy, done, aborted;
    logic [2:0]  pri_out;
    logic [31:0] bus_addr;

    gp_dma_chan_req dut (
        .cbus_clk_i    (clk),
        .cbus_rst_i    (rst),
        .cfg_start_i   (cfg_start),
        .cfg_abort_i   (cfg_abort),
        .cfg_addr_i    (cfg_addr),
        .cfg_len_i     (cfg_len),
        .cfg_burst_i   (cfg_burst),
        .cfg_pri_i     (cfg_pri),
        .owner_sel_i   (owner_sel),
        .cycle_start_i (cycle_start),
        .dma_pending_o (dma_pending),
        .priority_o    (pri_out),
        .active_o      (active),
        .bus_valid_o   (bus_valid),
        .bus_addr_o    (bus_addr),
        .bus_ready_i   (bus_ready),
        .busy_o        (busy),
        .done_o        (done),
        .aborted_o     (aborted)
    );

    int          n_cmp = 0, n_err = 0;
    logic [31:0] beats[$];
    int          ten_q[$];
    int          act_cnt, done_cnt, rel_cnt, cur_ten, gcnt, rcnt;
    int          gdelay = 3;
    bit          arb_en = 1'b1;
    logic [3:0]  rdy_pat = 4'hF;
    bit          stall_pend;
    logic [31:0] stall_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drops pulses, drives arbiter/ready, records what the next edge accepts.
    task automatic step();
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        if (arb_en) begin
            if (dma_pending && !active && gcnt >= gdelay) begin
                owner_sel = 1'b1; cycle_start = 1'b1; gcnt = 0;
            end else begin
                owner_sel = 1'b0; cycle_start = 1'b0;
                gcnt = (dma_pending && !active) ? gcnt + 1 : 0;
            end
        end
        bus_ready = rdy_pat[rcnt % 4];
        rcnt++;
        if (stall_pend)
            chk("hold", {31'd0, bus_valid, bus_addr}, {31'd0, 1'b1, stall_addr});
        stall_pend = bus_valid && !bus_ready;
        stall_addr = bus_addr;
        if (bus_valid && bus_ready) begin
            beats.push_back(bus_addr);
            cur_ten++;
        end
        if (active) act_cnt++;
        if (done) done_cnt++;
        if (busy && !dma_pending && !done) begin
            rel_cnt++;
            ten_q.push_back(cur_ten);
            cur_ten = 0;
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [15:0] l, input logic [3:0] b, input logic [2:0] p);
        beats.delete(); ten_q.delete();
        act_cnt = 0; done_cnt = 0; rel_cnt = 0; cur_ten = 0; gcnt = 0; rcnt = 0; stall_pend = 0;
        cfg_addr = a; cfg_len = l; cfg_burst = b; cfg_pri = p; cfg_start = 1'b1;
    endtask

    task automatic run_done(input string tag, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done) begin seen = 1; break; end
        end
        chk({tag, "_timeout"}, 64'(seen), 64'd1);
        step();
    endtask

    task automatic chk_beats(input string tag, input logic [31:0] base, input int n);
        chk({tag, "_nbeats"}, 64'(beats.size()), 64'(n));
        for (int i = 0; i < n && i < beats.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 64'(beats[i]), 64'(base + 32'(4 * i)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; cfg_start = 0; cfg_abort = 0; cfg_addr = 0; cfg_len = 0;
        cfg_burst = 0; cfg_pri = 0; owner_sel = 0; cycle_start = 0; bus_ready = 0;
        repeat (3) step();
        chk("rst_flags", {dma_pending, active, bus_valid, busy, done, aborted}, 6'd0);
        chk("rst_addr_pri", {bus_addr, pri_out}, 35'd0);
        rst = 0;
        step();

        // single 4-beat burst
        start(32'h1000, 16'd4, 4'd4, 3'd5);
        step();
        chk("t1_pending", dma_pending, 1);
        chk("t1_pri", pri_out, 5);
        chk("t1_no_active", active, 0);
        for (int i = 0; i < 20; i++) begin step(); if (cycle_start) break; end
        step();
        chk("t1_grant_lat", {active, bus_valid, bus_addr}, {2'b11, 32'h1000});
        run_done("t1", 40);
        chk_beats("t1", 32'h1000, 4);
        chk("t1_act", act_cnt, 4);
        chk("t1_done", done_cnt, 1);
        chk("t1_aborted", aborted, 0);
        chk("t1_rel", rel_cnt, 1);

        // multi-tenure 4+4+2
        start(32'h1000, 16'd10, 4'd4, 3'd2);
        run_done("t2", 100);
        chk_beats("t2", 32'h1000, 10);
        chk("t2_ntens", ten_q.size(), 3);
        if (ten_q.size() == 3) chk("t2_tens", {ten_q[0][7:0], ten_q[1][7:0], ten_q[2][7:0]}, 24'h040402);
        chk("t2_rel", rel_cnt, 3);
        chk("t2_act", act_cnt, 10);

        // backpressure 1010
        rdy_pat = 4'b0101;
        start(32'h4000, 16'd4, 4'd0, 3'd1);
        run_done("t3", 60);
        chk_beats("t3", 32'h4000, 4);
        chk("t3_rel", rel_cnt, 1);
        rdy_pat = 4'hF;

        // burst clamp: 15 -> 8
        start(32'h6000, 16'd12, 4'd15, 3'd0);
        run_done("tc", 100);
        chk_beats("tc", 32'h6000, 12);
        if (ten_q.size() == 2) chk("tc_tens", {ten_q[0][7:0], ten_q[1][7:0]}, 16'h0804);
        else chk("tc_ntens", ten_q.size(), 2);

        // abort while beat 2 pending
        start(32'h5000, 16'd8, 4'd8, 3'd0);
        for (int i = 0; i < 30; i++) begin step(); if (beats.size() == 1) break; end
        chk("t4_first", beats.size(), 1);
        rdy_pat = 4'h0;
        step();
        chk("t4_pending_beat", {bus_valid, bus_addr}, {1'b1, 32'h5004});
        cfg_abort = 1; rdy_pat = 4'hF;
        run_done("t4", 30);
        chk_beats("t4", 32'h5000, 2);
        chk("t4_aborted", aborted, 1);
        chk("t4_rel", rel_cnt, 1);

        // abort in REQ; owner_sel without cycle_start is no grant
        arb_en = 0;
        start(32'h7000, 16'd4, 4'd4, 3'd3);
        owner_sel = 1; cycle_start = 0;
        step(); step();
        chk("t4b_req", {dma_pending, active}, 2'b10);
        cfg_abort = 1;
        run_done("t4b", 10);
        chk("t4b_beats", beats.size(), 0);
        chk("t4b_aborted", aborted, 1);
        chk("t4b_act", act_cnt, 0);
        owner_sel = 0; arb_en = 1;

        // zero length
        start(32'h8000, 16'd0, 4'd4, 3'd0);
        step();
        chk("t5_done", {done, dma_pending}, 2'b10);
        step();
        chk("t5_idle", {done, busy, aborted, dma_pending}, 4'b0000);

        // address wrap
        start(32'hFFFF_FFFC, 16'd2, 4'd0, 3'd0);
        run_done("t5w", 30);
        chk("t5w_n", beats.size(), 2);
        if (beats.size() == 2) chk("t5w_wrap", {beats[0], beats[1]}, {32'hFFFF_FFFC, 32'h0});

        // reset mid-XFER
        start(32'h9000, 16'd8, 4'd8, 3'd6);
        for (int i = 0; i < 20; i++) begin step(); if (active) break; end
        chk("t6_in_xfer", active, 1);
        step();
        rst = 1;
        step();
        chk("t6_rst_flags", {dma_pending, active, bus_valid, busy, done, aborted}, 6'd0);
        chk("t6_rst_addr_pri", {bus_addr, pri_out}, 35'd0);
        rst = 0;
        repeat (4) step();
        chk("t6_no_done", done_cnt, 0);

        // cfg_start while busy is ignored
        start(32'hA000, 16'd4, 4'd4, 3'd0);
        step();
        cfg_start = 1; cfg_addr = 32'hB000; cfg_len = 16'd1;
        run_done("t6b", 40);
        chk_beats("t6b", 32'hA000, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
